// File: rtl/tl_ul_sram_slave_if.sv
// TileLink-UL channel A/D bundle plus the SRAM port of the slave.
interface tl_ul_sram_slave_if #(
  parameter int W         = 4,
  parameter int A         = 32,
  parameter int Z         = 3,
  parameter int O         = 1,
  parameter int MEM_WORDS = 1024
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [2:0]     a_opcode_i;
  logic [2:0]     a_param_i;
  logic [Z-1:0]   a_size_i;
  logic [O-1:0]   a_source_i;
  logic [A-1:0]   a_address_i;
  logic [W-1:0]   a_mask_i;
  logic [8*W-1:0] a_data_i;
  logic           a_valid_i;
  logic           a_ready_o;

  logic [2:0]     d_opcode_o;
  logic [1:0]     d_param_o;
  logic [Z-1:0]   d_size_o;
  logic [O-1:0]   d_source_o;
  logic           d_sink_o;
  logic [8*W-1:0] d_data_o;
  logic           d_error_o;
  logic           d_valid_o;
  logic           d_ready_i;

  logic           mem_req_o;
  logic           mem_we_o;
  logic [AW-1:0]  mem_addr_o;
  logic [W-1:0]   mem_wmask_o;
  logic [8*W-1:0] mem_wdata_o;
  logic [8*W-1:0] mem_rdata_i;

  modport slave (
    input  a_opcode_i, a_param_i, a_size_i, a_source_i, a_address_i,
           a_mask_i, a_data_i, a_valid_i, d_ready_i, mem_rdata_i,
    output a_ready_o, d_opcode_o, d_param_o, d_size_o, d_source_o,
           d_sink_o, d_data_o, d_error_o, d_valid_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o
  );

  modport master (
    output a_opcode_i, a_param_i, a_size_i, a_source_i, a_address_i,
           a_mask_i, a_data_i, a_valid_i, d_ready_i,
    input  a_ready_o, d_opcode_o, d_param_o, d_size_o, d_source_o,
           d_sink_o, d_data_o, d_error_o, d_valid_o
  );

  modport mem (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/tl_ul_sram_slave.sv
// TileLink-UL slave terminating Get/PutFullData/PutPartialData on a
// synchronous single-port SRAM, with credit-limited in-order responses.
module tl_ul_sram_slave #(
  parameter int W          = 4,
  parameter int A          = 32,
  parameter int Z          = 3,
  parameter int O          = 1,
  parameter int MEM_WORDS  = 1024,
  parameter int RESP_DEPTH = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  tl_ul_sram_slave_if.slave  bus
);
  localparam int DW = 8 * W;
  localparam int LW = $clog2(W);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 2);

  localparam logic [2:0] OP_PUT_FULL  = 3'd0;
  localparam logic [2:0] OP_PUT_PART  = 3'd1;
  localparam logic [2:0] OP_GET       = 3'd4;
  localparam logic [2:0] OP_ACK       = 3'd0;
  localparam logic [2:0] OP_ACK_DATA  = 3'd1;
  localparam logic [A:0] MEM_BYTES    = (A+1)'(MEM_WORDS * W);

  // Byte lanes covered by a naturally aligned 2^size transfer at addr.
  function automatic logic [W-1:0] lane_mask(input logic [A-1:0] addr,
                                             input logic [Z-1:0] size);
    logic [W-1:0] m;
    int           off;
    off = int'(addr & A'(W - 1));
    for (int i = 0; i < W; i++) m[i] = (((i ^ off) >> size) == 0);
    return m;
  endfunction

  // All channel A legality rules folded into one flag.
  function automatic logic req_legal(input logic [2:0]   op,
                                     input logic [Z-1:0] size,
                                     input logic [A-1:0] addr,
                                     input logic [W-1:0] mask);
    logic [W-1:0] lanes;
    logic [A-1:0] low;
    logic         op_ok, size_ok, align_ok, range_ok, mask_ok;
    op_ok    = (op == OP_GET) || (op == OP_PUT_FULL) || (op == OP_PUT_PART);
    size_ok  = (size <= Z'(LW));
    low      = ~({A{1'b1}} << size);
    align_ok = ((addr & low) == '0);
    range_ok = ({1'b0, addr} < MEM_BYTES);
    lanes    = lane_mask(addr, size);
    if (op == OP_PUT_PART) mask_ok = ((mask & ~lanes) == '0);
    else                   mask_ok = (mask == lanes);
    return op_ok && size_ok && align_ok && range_ok && mask_ok;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Stage p0: request acceptance and SRAM strobe
  logic          rdy_q;
  logic          a_fire_p0;
  logic          legal_p0;
  logic          mem_req_p0;

  // Stage p1: request in flight while SRAM read data arrives
  logic          vld_p1;
  logic [2:0]    opcode_p1;
  logic [Z-1:0]  size_p1;
  logic [O-1:0]  source_p1;
  logic          error_p1;
  logic          rd_sel_p1;

  // Response queue
  logic [2:0]    q_opcode [RESP_DEPTH];
  logic [Z-1:0]  q_size   [RESP_DEPTH];
  logic [O-1:0]  q_source [RESP_DEPTH];
  logic          q_error  [RESP_DEPTH];
  logic [DW-1:0] q_data   [RESP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop, rdy_next, d_vld;

  assign a_fire_p0  = bus.a_valid_i && rdy_q;
  assign legal_p0   = req_legal(bus.a_opcode_i, bus.a_size_i, bus.a_address_i, bus.a_mask_i);
  assign mem_req_p0 = a_fire_p0 && legal_p0;

  assign bus.a_ready_o   = rdy_q;
  assign bus.mem_req_o   = mem_req_p0;
  assign bus.mem_we_o    = mem_req_p0 && (bus.a_opcode_i != OP_GET);
  assign bus.mem_wmask_o = bus.mem_we_o ? bus.a_mask_i : '0;
  assign bus.mem_wdata_o = mem_req_p0 ? bus.a_data_i : '0;
  assign bus.mem_addr_o  = mem_req_p0 ? bus.a_address_i[LW +: AW] : '0;

  assign push  = vld_p1;
  assign d_vld = (count != '0);
  assign pop   = d_vld && bus.d_ready_i;

  // Next occupancy and the credit it leaves for the following cycle.
  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
    rdy_next   = ((count_next + CW'(a_fire_p0)) < CW'(RESP_DEPTH));
  end

  // Control state: credits, in-flight valid and queue pointers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdy_q  <= 1'b0;
      vld_p1 <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rdy_q  <= rdy_next;
      vld_p1 <= a_fire_p0;
      count  <= count_next;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Data path: capture request info, then write the response entry.
  always_ff @(posedge clk_i) begin
    if (a_fire_p0) begin
      opcode_p1 <= (bus.a_opcode_i == OP_GET) ? OP_ACK_DATA : OP_ACK;
      size_p1   <= bus.a_size_i;
      source_p1 <= bus.a_source_i;
      error_p1  <= !legal_p0;
      rd_sel_p1 <= legal_p0 && (bus.a_opcode_i == OP_GET);
    end
    if (push) begin
      q_opcode[wr_ptr] <= opcode_p1;
      q_size[wr_ptr]   <= size_p1;
      q_source[wr_ptr] <= source_p1;
      q_error[wr_ptr]  <= error_p1;
      q_data[wr_ptr]   <= rd_sel_p1 ? bus.mem_rdata_i : '0;
    end
  end

  assign bus.d_valid_o  = d_vld;
  assign bus.d_opcode_o = d_vld ? q_opcode[rd_ptr] : '0;
  assign bus.d_size_o   = d_vld ? q_size[rd_ptr]   : '0;
  assign bus.d_source_o = d_vld ? q_source[rd_ptr] : '0;
  assign bus.d_error_o  = d_vld ? q_error[rd_ptr]  : 1'b0;
  assign bus.d_data_o   = d_vld ? q_data[rd_ptr]   : '0;
  assign bus.d_param_o  = '0;
  assign bus.d_sink_o   = 1'b0;
endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// Scoreboard bench for tl_ul_sram_slave with a behavioural SRAM.
module tb_tl_ul_sram_slave;
  localparam int MW = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;
  int   last_fire = 0;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic        src;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];

  logic [31:0] mem [MW];

  tl_ul_sram_slave_if #(.W(4), .A(32), .Z(3), .O(1), .MEM_WORDS(MW)) bus ();

  tl_ul_sram_slave #(.W(4), .A(32), .Z(3), .O(1), .MEM_WORDS(MW), .RESP_DEPTH(3)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM: read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_req_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask_o[b]) mem[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end else begin
        bus.mem_rdata_i <= mem[bus.mem_addr_o];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every D beat is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.d_valid_o && bus.d_ready_i) begin
      ncmp++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL d_beat: unexpected response op=%0h data=%0h", bus.d_opcode_o, bus.d_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({bus.d_opcode_o, bus.d_size_o, bus.d_source_o, bus.d_error_o, bus.d_data_o,
             bus.d_param_o, bus.d_sink_o} !== {e.op, e.size, e.src, e.err, e.data, 2'b00, 1'b0}) begin
          nfail++;
          $display("FAIL d_beat: got op=%0h size=%0h src=%0h err=%0h data=%08h required op=%0h size=%0h src=%0h err=%0h data=%08h",
                   bus.d_opcode_o, bus.d_size_o, bus.d_source_o, bus.d_error_o, bus.d_data_o,
                   e.op, e.size, e.src, e.err, e.data);
        end
      end
    end
  end

  // Offer one A beat for up to budget cycles; the expectation is queued at fire.
  task automatic send(input logic [2:0] op, input logic [2:0] size, input logic src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                      input logic [2:0] eop, input logic eerr, input logic [31:0] edata,
                      input int budget, output bit fired);
    exp_t e;
    bus.a_opcode_i  = op;
    bus.a_param_i   = 3'd0;
    bus.a_size_i    = size;
    bus.a_source_i  = src;
    bus.a_address_i = addr;
    bus.a_mask_i    = mask;
    bus.a_data_i    = data;
    bus.a_valid_i   = 1'b1;
    fired = 1'b0;
    for (int k = 0; k < budget && !fired; k++) begin
      @(negedge clk);
      if (bus.a_ready_o) begin
        e = '{op: eop, size: size, src: src, err: eerr, data: edata};
        exp_q.push_back(e);
        chk("mem_req", 64'(bus.mem_req_o), 64'(!eerr));
        if (!eerr) begin
          chk("mem_we", 64'(bus.mem_we_o), 64'(op != 3'd4));
          chk("mem_wmask", 64'(bus.mem_wmask_o), (op == 3'd4) ? 64'd0 : 64'(mask));
        end
        last_fire = cyc;
        fired = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [2:0] size, input logic src,
                     input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                     input logic [2:0] eop, input logic eerr, input logic [31:0] edata);
    bit f;
    send(op, size, src, addr, mask, data, eop, eerr, edata, 20, f);
    chk("accept", 64'(f), 64'd1);
  endtask

  task automatic idle();
    bus.a_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit f;
    int acc;
    int first;
    bus.a_valid_i   = 1'b0;
    bus.a_opcode_i  = 3'd0;
    bus.a_param_i   = 3'd0;
    bus.a_size_i    = 3'd0;
    bus.a_source_i  = 1'b0;
    bus.a_address_i = 32'd0;
    bus.a_mask_i    = 4'd0;
    bus.a_data_i    = 32'd0;
    bus.d_ready_i   = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", 64'(bus.a_ready_o), 64'd0);
    chk("rst_d_valid", 64'(bus.d_valid_o), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // PutFull then Get
    req(3'd0, 3'd2, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 3'd0, 1'b0, 32'h0);
    req(3'd4, 3'd2, 1'b1, 32'h10, 4'hF, 32'h0,       3'd1, 1'b0, 32'hDEADBEEF);
    // PutPartial low halfword then Get
    req(3'd1, 3'd1, 1'b0, 32'h10, 4'h3, 32'h0000CAFE, 3'd0, 1'b0, 32'h0);
    req(3'd4, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADCAFE);
    // Protocol and range errors
    req(3'd4, 3'd2, 1'b1, 32'h11,    4'hF, 32'h0, 3'd1, 1'b1, 32'h0);
    req(3'd4, 3'd2, 1'b0, 4*MW,      4'hF, 32'h0, 3'd1, 1'b1, 32'h0);
    req(3'd2, 3'd2, 1'b1, 32'h14,    4'hF, 32'h0, 3'd0, 1'b1, 32'h0);
    req(3'd4, 3'd2, 1'b0, 32'h14,    4'h3, 32'h0, 3'd1, 1'b1, 32'h0);
    // Preload five words for the flow-control tests
    for (int i = 0; i < 5; i++)
      req(3'd0, 3'd2, 1'b0, 32'h20 + 4*i, 4'hF, 32'hA5A50000 + i, 3'd0, 1'b0, 32'h0);
    idle();
    drain();

    // Backpressure: only three credits
    bus.d_ready_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      send(3'd4, 3'd2, i[0], 32'h20 + 4*i, 4'hF, 32'h0, 3'd1, 1'b0, 32'hA5A50000 + i, 6, f);
      if (f) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'd3);
    @(negedge clk);
    chk("bp_a_ready", 64'(bus.a_ready_o), 64'd0);
    @(posedge clk); #1;
    bus.d_ready_i = 1'b1;
    req(3'd4, 3'd2, 1'b1, 32'h2C, 4'hF, 32'h0, 3'd1, 1'b0, 32'hA5A50003);
    req(3'd4, 3'd2, 1'b0, 32'h30, 4'hF, 32'h0, 3'd1, 1'b0, 32'hA5A50004);
    idle();
    drain();

    // Streaming: eight back-to-back Gets
    pop_cyc.delete();
    first = 0;
    for (int i = 0; i < 8; i++) begin
      send(3'd4, 3'd2, i[0], 32'h20 + 4*(i % 5), 4'hF, 32'h0, 3'd1, 1'b0, 32'hA5A50000 + (i % 5), 1, f);
      chk("stream_ready", 64'(f), 64'd1);
      if (i == 0) first = last_fire;
    end
    idle();
    drain();
    chk("stream_beats", 64'(pop_cyc.size()), 64'd8);
    if (pop_cyc.size() == 8) begin
      chk("stream_latency", 64'(pop_cyc[0] - first), 64'd2);
      for (int i = 1; i < 8; i++) chk("stream_gap", 64'(pop_cyc[i] - pop_cyc[0]), 64'(i));
    end

    // Reset mid-run: outputs cleared, memory contents persist
    rst = 1'b1;
    bus.a_opcode_i  = 3'd4;
    bus.a_address_i = 32'h10;
    bus.a_valid_i   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst2_a_ready", 64'(bus.a_ready_o), 64'd0);
    chk("rst2_mem_req", 64'(bus.mem_req_o), 64'd0);
    chk("rst2_d_valid", 64'(bus.d_valid_o), 64'd0);
    @(posedge clk); #1;
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    req(3'd4, 3'd2, 1'b1, 32'h10, 4'hF, 32'h0, 3'd1, 1'b0, 32'hDEADCAFE);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
